// File: rtl/soc_system_sph_pio_pkg.sv
// Shared definitions for the lightweight-bridge PIO pair (input and output).
// Holds the register map and the edge-capture sense encodings.
package soc_system_sph_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_sync_edge.sv
// Input synchroniser, previous-value register and per-bit edge select.
// Edge select stays quiet during a short warm-up after reset so pins held high never look like edges.
module pio_in_sync_edge
    import soc_system_sph_pio_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int EDGE_TYPE = EDGE_RISING,
    parameter int SYNC_STG  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] sel
);

    localparam logic [2:0] WARM_INIT = 3'(SYNC_STG + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STG];
    logic [WIDTH-1:0] sync_d [SYNC_STG];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       warm_q, warm_d;
    logic [WIDTH-1:0] rise, fall;

    assign s = sync_q[SYNC_STG-1];

    always_comb begin
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STG; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = s;
        warm_d = (warm_q != 3'd0) ? warm_q - 3'd1 : 3'd0;
    end

    always_comb begin
        rise = s & ~prev_q;
        fall = ~s & prev_q;
        sel  = '0;
        if (warm_q == 3'd0) begin
            case (EDGE_TYPE)
                EDGE_FALLING: sel = fall;
                EDGE_ANY:     sel = rise | fall;
                default:      sel = rise;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STG; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
            warm_q <= WARM_INIT;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

endmodule

// File: rtl/soc_system_sph_pio_in.sv
// Avalon-MM input PIO: data/mask/edge-capture register file, read mux and level irq.
// Reads have a fixed one-cycle latency and always return the values held before any same-cycle write.
module soc_system_sph_pio_in
    import soc_system_sph_pio_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int EDGE_TYPE = EDGE_RISING,
    parameter int SYNC_STG  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s, sel;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q, readdata_d, rd_word;
    logic             irq_q, irq_d;
    logic             wr_en, rd_en;
    logic             unused_wd;

    assign unused_wd = ^writedata;

    pio_in_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE),
        .SYNC_STG  (SYNC_STG)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .s       (s),
        .sel     (sel)
    );

    always_comb begin
        wr_en  = chipselect & ~write_n;
        rd_en  = chipselect & read;
        clr    = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        mask_d = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        // a new edge on the same cycle as its clear keeps the bit set
        edge_d = (edge_q & ~clr) | sel;
        irq_d  = |(edge_q & mask_q);

        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word[WIDTH-1:0] = s;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_q;
            default:   rd_word = '0;
        endcase
        readdata_d = rd_en ? rd_word : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
